// File: rtl/alp_carry_shift_ctl.sv
// rtl/alp_carry_shift_ctl.sv - ALP slice carry chain, shift links, shift sequencer and condition codes
// Optional feature: define ALP_ROTATE_EN to build the rotate-mode wrap paths.
module alp_carry_shift_ctl #(
   parameter int SLICES = 8
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic [SLICES-1:0] g_h,
   input  logic [SLICES-1:0] p_h,
   input  logic              v_msb_h,
   input  logic [SLICES-1:0] wmuxz_l,
   input  logic [SLICES-1:0] shl_sout_h,
   input  logic [SLICES-1:0] shr_sout_h,
   output logic [SLICES-1:0] carry_in_h,
   output logic [SLICES-1:0] shl_sin_h,
   output logic [SLICES-1:0] shr_sin_h,
   input  logic [1:0]        cin_sel_h,
   input  logic              start_h,
   input  logic [4:0]        count_h,
   input  logic              dir_h,
   input  logic [1:0]        mode_h,
   output logic              busy_h,
   output logic              shift_step_h,
   output logic              done_h,
   input  logic              cc_load_h,
   output logic              cc_n_h,
   output logic              cc_z_h,
   output logic              cc_v_h,
   output logic              cc_c_h
);

   localparam logic [1:0] MODE_ARITH = 2'b01;
`ifdef ALP_ROTATE_EN
   localparam logic [1:0] MODE_ROT   = 2'b10;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   state_t      state_q;
   logic [4:0]  rem_q;
   logic        dir_q;
   logic [1:0]  mode_q;
   logic        busy_q;
   logic        step_q;
   logic        done_q;

   logic        cc_n_q, cc_z_q, cc_v_q, cc_c_q;
   logic        cc_n_d, cc_z_d, cc_v_d, cc_c_d;

   logic [SLICES:0] c;
   logic [1:0]      eff_mode;
   logic            fill_l;
   logic            fill_r;

   // The C flag doubles as the saved carry fed back through cin_sel_h.
   always_comb begin
      c = '0;
      case (cin_sel_h)
         2'b00:   c[0] = 1'b0;
         2'b01:   c[0] = 1'b1;
         2'b10:   c[0] = cc_c_q;
         default: c[0] = ~cc_c_q;
      endcase
      for (int i = 0; i < SLICES; i++) begin
         c[i+1] = g_h[i] | (p_h[i] & c[i]);
      end
   end

   assign carry_in_h = c[SLICES-1:0];

   always_comb begin
      eff_mode = (state_q == ST_SHIFT) ? mode_q : mode_h;
      fill_l   = 1'b0;
      fill_r   = 1'b0;
      if (eff_mode == MODE_ARITH) begin
         fill_r = shl_sout_h[SLICES-1];
      end
`ifdef ALP_ROTATE_EN
      if (eff_mode == MODE_ROT) begin
         fill_l = shl_sout_h[SLICES-1];
         fill_r = shr_sout_h[0];
      end
`endif
   end

   assign shl_sin_h = {shl_sout_h[SLICES-2:0], fill_l};
   assign shr_sin_h = {fill_r, shr_sout_h[SLICES-1:1]};

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 2'b00;
         busy_q  <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_h) begin
                  rem_q  <= count_h;
                  dir_q  <= dir_h;
                  mode_q <= mode_h;
                  busy_q <= 1'b1;
                  if (count_h == 5'd0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_SHIFT;
                     step_q  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               rem_q <= rem_q - 5'd1;
               if (rem_q == 5'd1) begin
                  state_q <= ST_DONE;
                  step_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               step_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // A shift step owns C; a coincident cc load still updates N, Z and V.
   always_comb begin
      cc_n_d = cc_n_q;
      cc_z_d = cc_z_q;
      cc_v_d = cc_v_q;
      cc_c_d = cc_c_q;
      if (cc_load_h) begin
         cc_n_d = shl_sout_h[SLICES-1];
         cc_z_d = ~|wmuxz_l;
         cc_v_d = v_msb_h;
         cc_c_d = c[SLICES];
      end
      if (step_q) begin
         cc_c_d = dir_q ? shr_sout_h[0] : shl_sout_h[SLICES-1];
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cc_n_q <= 1'b0;
         cc_z_q <= 1'b0;
         cc_v_q <= 1'b0;
         cc_c_q <= 1'b0;
      end else begin
         cc_n_q <= cc_n_d;
         cc_z_q <= cc_z_d;
         cc_v_q <= cc_v_d;
         cc_c_q <= cc_c_d;
      end
   end

   assign busy_h       = busy_q;
   assign shift_step_h = step_q;
   assign done_h       = done_q;
   assign cc_n_h       = cc_n_q;
   assign cc_z_h       = cc_z_q;
   assign cc_v_h       = cc_v_q;
   assign cc_c_h       = cc_c_q;

endmodule

// File: tb/tb_alp_carry_shift_ctl.sv
// tb/tb_alp_carry_shift_ctl.sv - self-checking bench for alp_carry_shift_ctl
module tb_alp_carry_shift_ctl;
   localparam int S = 8;
`ifdef ALP_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_l = 1'b0;
   logic [S-1:0]  g_h = '0, p_h = '0, wmuxz_l = '1, shl_sout_h = '0, shr_sout_h = '0;
   logic          v_msb_h = 1'b0;
   logic [S-1:0]  carry_in_h, shl_sin_h, shr_sin_h;
   logic [1:0]    cin_sel_h = 2'b00, mode_h = 2'b00;
   logic          start_h = 1'b0, dir_h = 1'b0, cc_load_h = 1'b0;
   logic [4:0]    count_h = '0;
   logic          busy_h, shift_step_h, done_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alp_carry_shift_ctl #(.SLICES(S)) dut (
      .clk(clk), .reset_l(reset_l), .g_h(g_h), .p_h(p_h), .v_msb_h(v_msb_h),
      .wmuxz_l(wmuxz_l), .shl_sout_h(shl_sout_h), .shr_sout_h(shr_sout_h),
      .carry_in_h(carry_in_h), .shl_sin_h(shl_sin_h), .shr_sin_h(shr_sin_h),
      .cin_sel_h(cin_sel_h), .start_h(start_h), .count_h(count_h), .dir_h(dir_h),
      .mode_h(mode_h), .busy_h(busy_h), .shift_step_h(shift_step_h), .done_h(done_h),
      .cc_load_h(cc_load_h), .cc_n_h(cc_n_h), .cc_z_h(cc_z_h), .cc_v_h(cc_v_h), .cc_c_h(cc_c_h)
   );

   // Carry into slice i as a sum of products: some lower slice generates and
   // every slice in between propagates, or chain carry-in propagates all the way.
   function automatic logic [S:0] ref_carries(input logic [S-1:0] g, input logic [S-1:0] p, input logic cin);
      logic [S:0] r;
      logic all_p, term;
      for (int i = 0; i <= S; i++) begin
         all_p = 1'b1;
         for (int j = 0; j < i; j++) all_p = all_p & p[j];
         r[i] = cin & all_p;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) term = term & p[k];
            r[i] = r[i] | term;
         end
      end
      return r;
   endfunction

   task automatic test_reset();
      #1;
      checks++;
      if ({busy_h, shift_step_h, done_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000000", {busy_h, shift_step_h, done_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h});
      end
      checks++;
      if (carry_in_h !== 8'h00) begin
         errors++;
         $display("FAIL reset_carry: got %h expected 00", carry_in_h);
      end
      @(negedge clk);
      reset_l = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({busy_h, shift_step_h, done_h, cc_c_h} !== 4'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got %b expected 0000", {busy_h, shift_step_h, done_h, cc_c_h});
      end
   endtask

   task automatic test_carry();
      @(negedge clk);
      g_h = 8'h00; p_h = 8'hFF; cin_sel_h = 2'b01;
      #1;
      checks++;
      if (carry_in_h !== 8'hFF) begin
         errors++;
         $display("FAIL carry_prop_all: got %h expected ff", carry_in_h);
      end
      cc_load_h = 1'b1;
      @(negedge clk);
      cc_load_h = 1'b0;
      #1;
      checks++;
      if (cc_c_h !== 1'b1) begin
         errors++;
         $display("FAIL cc_c_carry_out: got %b expected 1", cc_c_h);
      end
      g_h = 8'h01; p_h = 8'h00; cin_sel_h = 2'b10;
      #1;
      checks++;
      if (carry_in_h !== 8'h03) begin
         errors++;
         $display("FAIL carry_saved: got %h expected 03", carry_in_h);
      end
      cin_sel_h = 2'b11;
      #1;
      checks++;
      if (carry_in_h !== 8'h02) begin
         errors++;
         $display("FAIL carry_saved_inv: got %h expected 02", carry_in_h);
      end
      wmuxz_l = 8'h00; shl_sout_h = 8'h80; v_msb_h = 1'b1; cc_load_h = 1'b1;
      @(negedge clk);
      cc_load_h = 1'b0;
      #1;
      checks++;
      if ({cc_n_h, cc_z_h, cc_v_h, cc_c_h} !== 4'b1110) begin
         errors++;
         $display("FAIL cc_load_nzvc: got %b expected 1110", {cc_n_h, cc_z_h, cc_v_h, cc_c_h});
      end
      wmuxz_l = 8'hFF; shl_sout_h = 8'h00; v_msb_h = 1'b0;
   endtask

   task automatic test_shift_seq();
      int steps;
      logic last_out;
      steps = 0;
      last_out = 1'b0;
      @(negedge clk);
      start_h = 1'b1; count_h = 5'd3; dir_h = 1'b0; mode_h = 2'b00;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start_h = 1'b0;
         shl_sout_h = 8'($urandom);
         #1;
         if (shift_step_h === 1'b1) steps++;
         checks++;
         if ({shift_step_h, done_h, busy_h} !== {k >= 1 && k <= 3, k == 4, k >= 1 && k <= 4}) begin
            errors++;
            $display("FAIL seq3_cycle%0d: step/done/busy got %b%b%b expected %b%b%b", k, shift_step_h, done_h, busy_h,
                     k <= 3, k == 4, k <= 4);
         end
         checks++;
         if (shl_sin_h[0] !== 1'b0) begin
            errors++;
            $display("FAIL seq3_fill_cycle%0d: shl_sin0 got %b expected 0", k, shl_sin_h[0]);
         end
         if (k == 4) begin
            checks++;
            if (cc_c_h !== last_out) begin
               errors++;
               $display("FAIL seq3_shift_c: got %b expected %b", cc_c_h, last_out);
            end
         end
         if (k == 3) last_out = shl_sout_h[7];
      end
      checks++;
      if (steps != 3) begin
         errors++;
         $display("FAIL seq3_step_count: got %0d expected 3", steps);
      end
   endtask

   task automatic test_fills();
      logic [S-1:0] r;
      @(negedge clk);
      mode_h = 2'b01; dir_h = 1'b1;
      r = 8'($urandom);
      shr_sout_h = r; shl_sout_h = 8'h80;
      #1;
      checks++;
      if (shr_sin_h !== {1'b1, r[7:1]}) begin
         errors++;
         $display("FAIL arith_right: got %h expected %h", shr_sin_h, {1'b1, r[7:1]});
      end
      mode_h = 2'b10;
      for (int b = 0; b < 2; b++) begin
         r = 8'($urandom);
         shl_sout_h = {b[0], r[6:0]};
         shr_sout_h = 8'($urandom);
         #1;
         checks++;
         if (shl_sin_h !== {r[6:0], ROT & b[0]}) begin
            errors++;
            $display("FAIL rotate_left_b%0d: got %h expected %h", b, shl_sin_h, {r[6:0], ROT & b[0]});
         end
         checks++;
         if (shr_sin_h[7] !== (ROT & shr_sout_h[0])) begin
            errors++;
            $display("FAIL rotate_right_b%0d: got %b expected %b", b, shr_sin_h[7], ROT & shr_sout_h[0]);
         end
      end
      mode_h = 2'b11; shl_sout_h = 8'h80; shr_sout_h = 8'h01;
      #1;
      checks++;
      if ({shr_sin_h[7], shl_sin_h[0]} !== 2'b00) begin
         errors++;
         $display("FAIL reserved_mode: got %b expected 00", {shr_sin_h[7], shl_sin_h[0]});
      end
   endtask

   task automatic test_latched_fill();
      @(negedge clk);
      start_h = 1'b1; count_h = 5'd4; dir_h = 1'b1; mode_h = 2'b01;
      @(negedge clk);
      start_h = 1'b0; mode_h = 2'b00; shl_sout_h = 8'h80;
      @(negedge clk);
      #1;
      checks++;
      if ({shift_step_h, shr_sin_h[7]} !== 2'b11) begin
         errors++;
         $display("FAIL latched_mode_fill: step/fill got %b expected 11", {shift_step_h, shr_sin_h[7]});
      end
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if ({busy_h, shr_sin_h[7]} !== 2'b00) begin
         errors++;
         $display("FAIL live_mode_after_seq: busy/fill got %b expected 00", {busy_h, shr_sin_h[7]});
      end
   endtask

   task automatic test_count_zero();
      @(negedge clk);
      start_h = 1'b1; count_h = 5'd0;
      @(negedge clk);
      start_h = 1'b0;
      #1;
      checks++;
      if ({shift_step_h, done_h, busy_h} !== 3'b011) begin
         errors++;
         $display("FAIL count0_cycle1: got %b expected 011", {shift_step_h, done_h, busy_h});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({shift_step_h, done_h, busy_h} !== 3'b000) begin
         errors++;
         $display("FAIL count0_cycle2: got %b expected 000", {shift_step_h, done_h, busy_h});
      end
   endtask

   task automatic test_back_to_back();
      int steps, dones;
      steps = 0; dones = 0;
      @(negedge clk);
      start_h = 1'b1; count_h = 5'd5;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start_h = (k == 2 || k == 3);
         count_h = (k == 1) ? 5'd5 : 5'd2;
         #1;
         if (shift_step_h === 1'b1) steps++;
         if (done_h === 1'b1) begin
            dones++;
            checks++;
            if (k != 6) begin
               errors++;
               $display("FAIL busy_start_done_cycle: got %0d expected 6", k);
            end
         end
      end
      start_h = 1'b0;
      checks++;
      if (steps != 5 || dones != 1) begin
         errors++;
         $display("FAIL busy_start_ignored: steps=%0d dones=%0d expected 5 and 1", steps, dones);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      @(negedge clk);
      g_h = 8'h00; p_h = 8'hFF; cin_sel_h = 2'b01; wmuxz_l = 8'h00; shl_sout_h = 8'h80; v_msb_h = 1'b1;
      cc_load_h = 1'b1; start_h = 1'b1; count_h = 5'd10; dir_h = 1'b0;
      @(negedge clk);
      cc_load_h = 1'b0; start_h = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({busy_h, shift_step_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h} !== 6'b111111) begin
         errors++;
         $display("FAIL pre_reset_state: got %b expected 111111", {busy_h, shift_step_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h});
      end
      reset_l = 1'b0;
      #1;
      checks++;
      if ({busy_h, shift_step_h, done_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h} !== 7'b0) begin
         errors++;
         $display("FAIL mid_reset: got %b expected 0000000", {busy_h, shift_step_h, done_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h});
      end
      @(negedge clk);
      reset_l = 1'b1;
      wmuxz_l = 8'hFF; shl_sout_h = 8'h00; v_msb_h = 1'b0; cin_sel_h = 2'b00;
      repeat (12) begin
         @(negedge clk);
         #1;
         if (done_h === 1'b1) dones++;
      end
      checks++;
      if (dones != 0 || busy_h !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_no_done: dones=%0d busy=%b expected 0 and 0", dones, busy_h);
      end
   endtask

   // Timeline model: a start accepted in cycle s with distance n steps in
   // cycles s+1..s+n, pulses done at s+n+1 and is busy over s+1..s+n+1.
   task automatic test_random();
      int t, s, n;
      logic mdir, mn, mz, mv, mc;
      logic [1:0] mmode, em;
      logic in_step, exp_busy, exp_done, fl, fr, cin;
      logic [S:0] cr;
      t = 0; s = -10; n = 0; mdir = 0; mmode = 0;
      mn = 0; mz = 0; mv = 0; mc = 0;
      for (int it = 0; it < 500; it++) begin
         @(negedge clk);
         g_h = 8'($urandom); p_h = 8'($urandom);
         wmuxz_l = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         shl_sout_h = 8'($urandom); shr_sout_h = 8'($urandom);
         v_msb_h = 1'($urandom); cin_sel_h = 2'($urandom);
         start_h = ($urandom_range(0, 3) == 0);
         count_h = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
         dir_h = 1'($urandom); mode_h = 2'($urandom);
         cc_load_h = ($urandom_range(0, 2) == 0);
         #1;
         in_step  = (t > s) && (t <= s + n);
         exp_done = (t == s + n + 1);
         exp_busy = (t > s) && (t <= s + n + 1);
         em = in_step ? mmode : mode_h;
         fl = (ROT && em == 2'b10) ? shl_sout_h[7] : 1'b0;
         fr = (em == 2'b01) ? shl_sout_h[7] : ((ROT && em == 2'b10) ? shr_sout_h[0] : 1'b0);
         case (cin_sel_h)
            2'b00: cin = 1'b0;
            2'b01: cin = 1'b1;
            2'b10: cin = mc;
            default: cin = ~mc;
         endcase
         cr = ref_carries(g_h, p_h, cin);
         checks++;
         if (carry_in_h !== cr[S-1:0]) begin
            errors++;
            $display("FAIL rnd_carry t=%0d: got %h expected %h", t, carry_in_h, cr[S-1:0]);
         end
         checks++;
         if (shl_sin_h !== {shl_sout_h[6:0], fl} || shr_sin_h !== {fr, shr_sout_h[7:1]}) begin
            errors++;
            $display("FAIL rnd_links t=%0d: got %h/%h expected %h/%h", t, shl_sin_h, shr_sin_h,
                     {shl_sout_h[6:0], fl}, {fr, shr_sout_h[7:1]});
         end
         checks++;
         if ({shift_step_h, done_h, busy_h} !== {in_step, exp_done, exp_busy}) begin
            errors++;
            $display("FAIL rnd_seq t=%0d: step/done/busy got %b%b%b expected %b%b%b", t,
                     shift_step_h, done_h, busy_h, in_step, exp_done, exp_busy);
         end
         checks++;
         if ({cc_n_h, cc_z_h, cc_v_h, cc_c_h} !== {mn, mz, mv, mc}) begin
            errors++;
            $display("FAIL rnd_cc t=%0d: got %b expected %b", t, {cc_n_h, cc_z_h, cc_v_h, cc_c_h}, {mn, mz, mv, mc});
         end
         if (cc_load_h) begin
            mn = shl_sout_h[7];
            mz = (wmuxz_l == 8'h00);
            mv = v_msb_h;
            mc = cr[S];
         end
         if (in_step) mc = mdir ? shr_sout_h[0] : shl_sout_h[7];
         if (start_h && !exp_busy) begin
            s = t; n = int'(count_h); mdir = dir_h; mmode = mode_h;
         end
         t++;
      end
      @(negedge clk);
      start_h = 1'b0; cc_load_h = 1'b0;
   endtask

   initial begin
      test_reset();
      test_carry();
      test_shift_seq();
      test_fills();
      test_latched_fill();
      test_count_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
